// File: rtl/life_pkg.sv
// Shared types and default widths for the Game-of-Life generation scheduler.
package life_pkg;

    // Scheduler phases: wait for a trigger, pulse the engine, wait for the
    // engine, wait for a frame boundary, commit the buffer swap.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        RUN      = 3'd2,
        WAIT_VBL = 3'd3,
        SWAP     = 3'd4
    } sched_state_t;

    localparam int FPG_W_DEF = 8;
    localparam int GEN_W_DEF = 16;

endpackage

// File: rtl/life_gen_scheduler_if.sv
// Scheduler <-> cell-update engine handshake.
// Handshake: the scheduler (master) raises eng_start for exactly one clock to
// launch one generation; the engine (slave) answers with a one-clock eng_done
// pulse once the generation is written. No new eng_start is issued until the
// matching eng_done has been seen; eng_done arriving with no generation
// outstanding is ignored by the master.
interface life_gen_scheduler_if;
    logic eng_start;
    logic eng_done;

    modport master (output eng_start, input eng_done);
    modport slave  (input eng_start, output eng_done);
endinterface

// File: rtl/vsync_edge.sv
// Turns a sync signal of either polarity into a registered one-clock tick on
// its transition into the active level. Also usable for hsync line counting.
module vsync_edge #(
    parameter bit POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_i,
    output logic tick_o
);
    logic sync_q;
    logic tick_q;

    // History starts inactive so no tick can appear in the first cycle after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= ~POL;
            tick_q <= 1'b0;
        end else begin
            sync_q <= sync_i;
            tick_q <= (sync_i == POL) && (sync_q != POL);
        end
    end

    assign tick_o = tick_q;
endmodule

// File: rtl/life_gen_scheduler.sv
// Sequences cell-update generations against the VGA frame rate and swaps the
// ping-pong cell buffers only on a frame boundary.
module life_gen_scheduler
    import life_pkg::*;
#(
    parameter bit VSYNC_POL = 1'b1,
    parameter int FPG_W     = FPG_W_DEF,
    parameter int GEN_W     = GEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vsync,
    input  logic                 run_en,
    input  logic                 step_req,
    input  logic [FPG_W-1:0]     frames_per_gen,
    life_gen_scheduler_if.master eng,
    output logic                 disp_buf_sel,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 busy,
    output logic                 overrun,
    output sched_state_t         dbg_state
);
    sched_state_t     state_q, state_d;
    logic [FPG_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             buf_sel_q, buf_sel_d;
    logic [GEN_W-1:0] gen_cnt_q, gen_cnt_d;
    logic             overrun_q, overrun_d;
    logic             tick;
    logic             gen_due;
    logic [FPG_W-1:0] fpg_last;

    vsync_edge #(.POL(VSYNC_POL)) u_vsync_edge (
        .clk    (clk),
        .rst    (rst),
        .sync_i (vsync),
        .tick_o (tick)
    );

    // Last frame index of a generation period; a setting of 0 behaves as 1.
    // frames_per_gen is looked at only on ticks, so a change applies at the next compare.
    assign fpg_last = (frames_per_gen == '0) ? '0 : frames_per_gen - FPG_W'(1);
    assign gen_due  = tick && (frame_cnt_q == fpg_last);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; step_req only counts when not free-running and idle, never queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (run_en ? gen_due : step_req) state_d = START;
            START:    state_d = RUN;
            RUN:      if (eng.eng_done) state_d = WAIT_VBL;
            WAIT_VBL: if (tick) state_d = SWAP;
            SWAP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath registers: frame counter, buffer select, generation count, overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            buf_sel_q   <= 1'b0;
            gen_cnt_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            buf_sel_q   <= buf_sel_d;
            gen_cnt_q   <= gen_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    // Datapath next state. The counter keeps shadow-counting in RUN so a
    // generation that falls due while the engine is still busy flags overrun.
    // The swap is committed on the edge entering SWAP, so the new buffer
    // select is visible one clock after the tick, inside vertical blanking.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        buf_sel_d   = buf_sel_q;
        gen_cnt_d   = gen_cnt_q;
        overrun_d   = overrun_q;
        if (!run_en || state_q == SWAP) begin
            frame_cnt_d = '0;
        end else if (tick && (state_q == IDLE || state_q == RUN)) begin
            frame_cnt_d = gen_due ? '0 : frame_cnt_q + FPG_W'(1);
        end
        if (state_q == RUN && run_en && gen_due) overrun_d = 1'b1;
        if (state_q == WAIT_VBL && tick) begin
            buf_sel_d = ~buf_sel_q;
            gen_cnt_d = gen_cnt_q + GEN_W'(1);
        end
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        eng.eng_start = (state_q == START);
        busy          = (state_q != IDLE);
    end

    assign disp_buf_sel = buf_sel_q;
    assign gen_count    = gen_cnt_q;
    assign overrun      = overrun_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_life_gen_scheduler.sv
// Bench for life_gen_scheduler: scenario table, directed corner sequences,
// a VSYNC_POL=0 / narrow-counter build for wrap, and a randomized run
// against a frame-level reference model.
module tb_life_gen_scheduler;
    import life_pkg::*;

    localparam int FRAME  = 40;  // clocks per frame in directed runs
    localparam int RFRAME = 24;  // clocks per frame in the random run

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 1: positive vsync, 16-bit generation count ----------------
    logic         vsync = 1'b0, run_en = 1'b0, step_req = 1'b0;
    logic [7:0]   fpg = 8'd0;
    logic         buf_sel, busy, overrun;
    logic [15:0]  gen;
    sched_state_t dbg1;
    life_gen_scheduler_if eng1 ();

    life_gen_scheduler #(.VSYNC_POL(1'b1), .FPG_W(8), .GEN_W(16)) dut1 (
        .clk(clk), .rst(rst), .vsync(vsync), .run_en(run_en), .step_req(step_req),
        .frames_per_gen(fpg), .eng(eng1), .disp_buf_sel(buf_sel), .gen_count(gen),
        .busy(busy), .overrun(overrun), .dbg_state(dbg1)
    );

    // ---------------- DUT 2: negative vsync, 4-bit generation count ----------------
    logic         vsync2 = 1'b1, run2 = 1'b0, step2 = 1'b0;
    logic [7:0]   fpg2 = 8'd1;
    logic         buf2, busy2, ovr2;
    logic [3:0]   gen2;
    sched_state_t dbg2;
    life_gen_scheduler_if eng2 ();

    life_gen_scheduler #(.VSYNC_POL(1'b0), .FPG_W(8), .GEN_W(4)) dut2 (
        .clk(clk), .rst(rst), .vsync(vsync2), .run_en(run2), .step_req(step2),
        .frames_per_gen(fpg2), .eng(eng2), .disp_buf_sel(buf2), .gen_count(gen2),
        .busy(busy2), .overrun(ovr2), .dbg_state(dbg2)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;
    int start_seen = 0;

    always @(negedge clk) if (eng1.eng_start === 1'b1) start_seen <= start_seen + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic reset_all();
        rst = 1'b1;
        vsync = 1'b0; run_en = 1'b0; step_req = 1'b0; eng1.eng_done = 1'b0;
        vsync2 = 1'b1; run2 = 1'b0; step2 = 1'b0; eng2.eng_done = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Free-run DUT1 for a number of frames with an engine that answers after `delay` clocks.
    task automatic run_frames(input logic [7:0] f, input int delay, input int frames);
        int left;
        left = -1;
        fpg = f;
        run_en = 1'b1;
        for (int c = 0; c < frames * FRAME; c++) begin
            vsync = ((c % FRAME) < 4);
            eng1.eng_done = (left == 0);
            @(negedge clk);
            if (eng1.eng_start === 1'b1) left = delay;
            else if (left >= 0) left--;
            @(posedge clk); #1;
        end
        eng1.eng_done = 1'b0;
        vsync = 1'b0;
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        logic [7:0]  fpg;
        int          delay;
        int          frames;
        int          exp_starts;
        logic [15:0] exp_gen;
        logic        exp_buf;
        logic        exp_ovr;
    } row_t;
    row_t rows [6];

    // ---------------- reference model (frame-level view of the scheduler) ----------------
    bit          m_vs_prev, m_tick;
    bit          m_start_now, m_computing, m_await, m_swap_now;
    logic [7:0]  m_frames;
    logic        m_buf, m_ovr;
    logic [15:0] m_gen;

    task automatic model_reset();
        m_vs_prev = 1'b0; m_tick = 1'b0;
        m_start_now = 1'b0; m_computing = 1'b0; m_await = 1'b0; m_swap_now = 1'b0;
        m_frames = 8'd0; m_buf = 1'b0; m_ovr = 1'b0; m_gen = 16'd0;
    endtask

    // Advance the model across one clock edge, given the inputs seen at that edge.
    task automatic model_step(input logic vs, input logic run, input logic step,
                              input logic done, input logic [7:0] f);
        logic [7:0] period_last;
        bit due, idle, n_start, n_comp, n_await, n_swap;
        logic [7:0] n_frames;
        period_last = (f == 8'd0) ? 8'd0 : f - 8'd1;
        due  = m_tick && (m_frames == period_last);
        idle = !(m_start_now || m_computing || m_await || m_swap_now);
        n_start = 1'b0; n_comp = m_computing; n_await = m_await; n_swap = 1'b0;
        n_frames = m_frames;
        if (idle) begin
            if (run ? due : step) n_start = 1'b1;
            if (run && m_tick) n_frames = due ? 8'd0 : m_frames + 8'd1;
        end
        if (m_start_now) n_comp = 1'b1;
        if (m_computing) begin
            if (run && m_tick) begin
                if (due) m_ovr = 1'b1;
                n_frames = due ? 8'd0 : m_frames + 8'd1;
            end
            if (done) begin n_comp = 1'b0; n_await = 1'b1; end
        end
        if (m_await && m_tick) begin
            n_await = 1'b0; n_swap = 1'b1;
            m_buf = ~m_buf; m_gen = m_gen + 16'd1;
        end
        if (m_swap_now || !run) n_frames = 8'd0;
        m_tick = vs && !m_vs_prev;
        m_vs_prev = vs;
        m_start_now = n_start; m_computing = n_comp; m_await = n_await; m_swap_now = n_swap;
        m_frames = n_frames;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base;
        int left;
        logic vs_c, run_c, step_c, done_c;
        logic [7:0] f_c;

        rows[0] = '{8'd3, 10, 12, 3, 16'd3, 1'b1, 1'b0};
        rows[1] = '{8'd0, 10,  8, 4, 16'd4, 1'b0, 1'b0};
        rows[2] = '{8'd1, 10,  8, 4, 16'd4, 1'b0, 1'b0};
        rows[3] = '{8'd1, 100, 6, 2, 16'd1, 1'b1, 1'b1};
        rows[4] = '{8'd2, 50,  8, 2, 16'd2, 1'b0, 1'b0};
        rows[5] = '{8'd2, 90,  8, 2, 16'd1, 1'b1, 1'b1};

        // Reset values
        reset_all();
        check("reset_state", {eng1.eng_start, busy, buf_sel, overrun, gen}, 32'd0);

        // Table-driven free-run scenarios
        for (int r = 0; r < 6; r++) begin
            reset_all();
            base = start_seen;
            run_frames(rows[r].fpg, rows[r].delay, rows[r].frames);
            check($sformatf("row%0d_starts", r), start_seen - base, rows[r].exp_starts);
            check($sformatf("row%0d_gen", r), gen, rows[r].exp_gen);
            check($sformatf("row%0d_buf", r), buf_sel, rows[r].exp_buf);
            check($sformatf("row%0d_overrun", r), overrun, rows[r].exp_ovr);
        end

        // Single step, second request while busy dropped, swap one clock after tick
        reset_all();
        base = start_seen;
        @(posedge clk); #1 step_req = 1'b1;
        @(posedge clk); #1 step_req = 1'b0;
        check("step_start", {eng1.eng_start, busy}, 2'b11);
        @(posedge clk); #1;
        check("step_start_one_cycle", eng1.eng_start, 1'b0);
        step_req = 1'b1;
        @(posedge clk); #1 step_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("step_running", {busy, gen}, {1'b1, 16'd0});
        eng1.eng_done = 1'b1;
        @(posedge clk); #1 eng1.eng_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("step_wait_vbl", 32'(dbg1), 32'(WAIT_VBL));
        vsync = 1'b1;
        @(posedge clk); #1;
        check("buf_at_tick", buf_sel, 1'b0);
        @(posedge clk); #1;
        check("buf_after_tick", {buf_sel, busy}, 2'b11);
        @(posedge clk); #1;
        check("step_complete", {busy, gen}, {1'b0, 16'd1});
        vsync = 1'b0;
        check("step_start_count", start_seen - base, 1);

        // Asynchronous reset in RUN
        step_req = 1'b1;
        @(posedge clk); #1 step_req = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_run", 32'(dbg1), 32'(RUN));
        #2 rst = 1'b1;
        #1;
        check("async_reset", {eng1.eng_start, busy, buf_sel, overrun, gen}, 32'd0);
        @(negedge clk) rst = 1'b0;
        base = start_seen;
        run_frames(8'd3, 10, 2);
        check("post_reset_no_start", {31'd0, busy} + 32'(start_seen - base), 32'd0);

        // Negative-polarity build: rising vsync ignored, falling swaps; 4-bit count wraps
        reset_all();
        for (int g = 1; g <= 16; g++) begin
            step2 = 1'b1;
            @(posedge clk); #1 step2 = 1'b0;
            @(posedge clk); #1;
            vsync2 = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            eng2.eng_done = 1'b1;
            @(posedge clk); #1 eng2.eng_done = 1'b0;
            vsync2 = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            check("pol_rise_ignored", {dbg2 == WAIT_VBL, gen2}, {1'b1, 4'(g - 1)});
            vsync2 = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("wrap_gen", {busy2, gen2}, {1'b0, 4'(g)});
            vsync2 = 1'b1;
            @(posedge clk); #1;
        end
        check("wrap_buf_ovr", {buf2, ovr2}, 2'b00);

        // Randomized run against the reference model
        reset_all();
        model_reset();
        left = -1;
        fpg = 8'd2;
        for (int c = 0; c < 3000; c++) begin
            vsync = ((c % RFRAME) < 3);
            if ($urandom_range(0, 99) < 3) run_en = ~run_en;
            if ($urandom_range(0, 199) == 0) fpg = 8'($urandom_range(0, 3));
            step_req = ($urandom_range(0, 9) == 0);
            eng1.eng_done = (left == 0) || (left < 0 && $urandom_range(0, 149) == 0);
            @(negedge clk);
            check("rand_cycle", {eng1.eng_start, busy, buf_sel, overrun, gen},
                  {m_start_now, (m_start_now || m_computing || m_await || m_swap_now),
                   m_buf, m_ovr, m_gen});
            if (eng1.eng_start === 1'b1) left = $urandom_range(5, 60);
            else if (left >= 0) left--;
            vs_c = vsync; run_c = run_en; step_c = step_req; done_c = eng1.eng_done; f_c = fpg;
            @(posedge clk);
            model_step(vs_c, run_c, step_c, done_c, f_c);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
